// File: rtl/pll_seq_pkg.sv
// pll_sequencer shared types: FSM states, clkout count and counter sizing.
// Optional PLL_SEQ_RETRY_EN build enables lock-timeout retries in the top.
package pll_seq_pkg;

  localparam int NUM_CLKOUT = 4;

  typedef enum logic [2:0] {
    IDLE,
    PLL_RST,
    WAIT_LOCK,
    SETTLE,
    ENABLE,
    RUN,
    FAULT
  } state_e;

  function automatic int cnt_w(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [NUM_CLKOUT-1:0] low_bit(
    input logic [NUM_CLKOUT-1:0] v
  );
    return v & (-v);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Resets to 0 so a stale lock is never seen after reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_sequencer.sv
// PLL bring-up/supervision FSM: reset pulse, lock wait, settle, staged enables.
// Define PLL_SEQ_RETRY_EN to retry lock timeouts up to MAX_RETRY times.
module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE    = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int SETTLE       = 256,
  parameter int EN_GAP       = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] out_mask,
  input  logic       lock,
  output logic       pll_en,
  output logic       pll_resetn,
  output logic [3:0] clkout_en,
  output logic       app_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int CW = cnt_w(RST_PULSE, LOCK_TIMEOUT, SETTLE, EN_GAP);

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] RST_LD = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SET_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(EN_GAP - 1);

`ifdef PLL_SEQ_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  // A zero limit makes the first timeout fatal.
  localparam logic [3:0] RETRY_LIM = RETRY_ON ? 4'(MAX_RETRY) : 4'd0;

  typedef logic [NUM_CLKOUT-1:0] oen_t;

  logic     lock_s;
  state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  oen_t     mask_q, mask_d;
  oen_t     en_q, en_d;
  oen_t     pend;
  logic [3:0] retry_q, retry_d;
  logic     pll_en_q, pll_en_d;
  logic     pll_resetn_q, pll_resetn_d;
  logic     app_rst_n_q, app_rst_n_d;
  logic     ready_q, ready_d;
  logic     fault_q, fault_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    en_d    = en_q;
    retry_d = retry_q;
    pend    = mask_q & ~en_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PLL_RST;
          cnt_d   = RST_LD;
          mask_d  = out_mask;
          retry_d = '0;
        end
      end
      PLL_RST: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = TO_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = pll_seq_pkg::SETTLE;
          cnt_d   = SET_LD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (retry_q < RETRY_LIM) begin
          state_d = PLL_RST;
          cnt_d   = RST_LD;
          retry_d = retry_q + 4'd1;
        end else begin
          state_d = FAULT;
          cnt_d   = '0;
        end
      end
      pll_seq_pkg::SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = TO_LD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (mask_q == '0) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          state_d = ENABLE;
          cnt_d   = GAP_LD;
          en_d    = low_bit(mask_q);
        end
      end
      ENABLE: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = RST_LD;
          en_d    = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (pend != '0) begin
          cnt_d = GAP_LD;
          en_d  = en_q | low_bit(pend);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        retry_d = '0;
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = RST_LD;
          en_d    = '0;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      en_d    = '0;
      retry_d = '0;
    end
  end

  // Outputs follow the next state so they change on the same edge.
  always_comb begin
    pll_en_d = state_d inside {PLL_RST, WAIT_LOCK,
                               pll_seq_pkg::SETTLE, ENABLE, RUN};
    pll_resetn_d = state_d inside {WAIT_LOCK,
                                   pll_seq_pkg::SETTLE, ENABLE, RUN};
    app_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      en_q         <= '0;
      retry_q      <= '0;
      pll_en_q     <= 1'b0;
      pll_resetn_q <= 1'b0;
      app_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      en_q         <= en_d;
      retry_q      <= retry_d;
      pll_en_q     <= pll_en_d;
      pll_resetn_q <= pll_resetn_d;
      app_rst_n_q  <= app_rst_n_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_en     = pll_en_q;
  assign pll_resetn = pll_resetn_q;
  assign clkout_en  = en_q;
  assign app_rst_n  = app_rst_n_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;

endmodule
